// File: rtl/defs_pkg.sv
// Shared types and helpers for the memory-port arbiter.
package defs_pkg;

   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_TIMEOUT    = 255;
   localparam int WD_WIDTH       = 8;

   // Arbiter sequencing: sample requests, run the memory access, acknowledge.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_MEM  = 2'd1,
      ARB_ACK  = 2'd2
   } arb_state_t;

   // Owner of the memory port; the encoding is visible on the grant output.
   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_IF   = 2'd1,
      GRANT_D    = 2'd2
   } mem_grant_t;

   // Request fields latched at grant time and driven onto the memory port.
   typedef struct packed {
      logic                      we;
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] wdata;
   } mem_req_t;

   // Single request wins outright; on a tie the requester that was not
   // served last goes first.
   function automatic mem_grant_t pick_winner(input logic       if_req,
                                              input logic       d_req,
                                              input mem_grant_t last);
      mem_grant_t win;
      win = GRANT_NONE;
      if (if_req && d_req) begin
         win = (last == GRANT_IF) ? GRANT_D : GRANT_IF;
      end else if (if_req) begin
         win = GRANT_IF;
      end else if (d_req) begin
         win = GRANT_D;
      end
      return win;
   endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Access watchdog: counts memory-wait cycles and flags the cycle on which the
// count would reach TIMEOUT.
module arb_watchdog
   import defs_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [WD_WIDTH-1:0] LIMIT = WD_WIDTH'(TIMEOUT);
   localparam logic [WD_WIDTH-1:0] LAST  = LIMIT - WD_WIDTH'(1);

   logic [WD_WIDTH-1:0] count_q;
   logic [WD_WIDTH-1:0] count_d;

   // Next count: clear wins, otherwise count enabled cycles and hold at LIMIT.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != LIMIT)) begin
         count_d = count_q + WD_WIDTH'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expiry is reported in the wait cycle that would bring the count to LIMIT,
   // so the owner sees its ack exactly TIMEOUT cycles after mem_req rose.
   assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Memory-port arbiter between instruction fetch and load/store data.
//
// Handshake: a requester raises *_req with its fields and holds them until
// its one-cycle *_ack; err qualifies that ack as a timed-out access. On the
// memory side mem_req and the mem_* fields stay constant until the cycle
// mem_ready is sampled high (or the watchdog expires). Requests are only
// looked at in ARB_IDLE, so a request still high after its ack is a new one.
module mem_arbiter
   import defs_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_ack,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_ack,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic [1:0]            grant,
   output arb_state_t            state_o
);

   arb_state_t            state_q;
   mem_grant_t            grant_q;
   mem_grant_t            last_grant_q;
   mem_req_t              req_q;
   logic                  mem_req_q;
   logic                  if_ack_q;
   logic                  d_ack_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] if_rdata_q;
   logic [DATA_WIDTH-1:0] d_rdata_q;

   mem_grant_t            winner_d;
   logic                  wd_clear;
   logic                  wd_enable;
   logic                  wd_expired;

   // Arbitration decision for the current idle cycle.
   always_comb begin
      winner_d = pick_winner(if_req, d_req, last_grant_q);
   end

   // The watchdog is held clear while idle and counts only memory-wait cycles.
   always_comb begin
      wd_clear  = (state_q == ARB_IDLE);
      wd_enable = (state_q == ARB_MEM) && !mem_ready;
   end

   arb_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (wd_clear),
      .enable_i (wd_enable),
      .expired_o(wd_expired)
   );

   // Arbiter FSM with every output registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ARB_IDLE;
         grant_q      <= GRANT_NONE;
         last_grant_q <= GRANT_IF;
         req_q        <= '0;
         mem_req_q    <= 1'b0;
         if_ack_q     <= 1'b0;
         d_ack_q      <= 1'b0;
         err_q        <= 1'b0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (winner_d != GRANT_NONE) begin
                  grant_q   <= winner_d;
                  mem_req_q <= 1'b1;
                  state_q   <= ARB_MEM;
                  if (winner_d == GRANT_IF) begin
                     // Fetches never write; the data field is parked at zero.
                     req_q.we    <= 1'b0;
                     req_q.addr  <= if_addr;
                     req_q.wdata <= '0;
                  end else begin
                     req_q.we    <= d_we;
                     req_q.addr  <= d_addr;
                     req_q.wdata <= d_wdata;
                  end
               end
            end

            ARB_MEM: begin
               if (mem_ready) begin
                  // A completion in the expiry cycle still counts as normal.
                  if (grant_q == GRANT_IF) begin
                     if_rdata_q <= mem_rdata;
                  end else if (!req_q.we) begin
                     d_rdata_q <= mem_rdata;
                  end
                  mem_req_q <= 1'b0;
                  if_ack_q  <= (grant_q == GRANT_IF);
                  d_ack_q   <= (grant_q == GRANT_D);
                  state_q   <= ARB_ACK;
               end else if (wd_expired) begin
                  if (grant_q == GRANT_IF) begin
                     if_rdata_q <= '0;
                  end else begin
                     d_rdata_q <= '0;
                  end
                  mem_req_q <= 1'b0;
                  err_q     <= 1'b1;
                  if_ack_q  <= (grant_q == GRANT_IF);
                  d_ack_q   <= (grant_q == GRANT_D);
                  state_q   <= ARB_ACK;
               end
            end

            ARB_ACK: begin
               if_ack_q     <= 1'b0;
               d_ack_q      <= 1'b0;
               err_q        <= 1'b0;
               last_grant_q <= grant_q;
               grant_q      <= GRANT_NONE;
               state_q      <= ARB_IDLE;
            end

            default: begin
               state_q   <= ARB_IDLE;
               grant_q   <= GRANT_NONE;
               mem_req_q <= 1'b0;
               if_ack_q  <= 1'b0;
               d_ack_q   <= 1'b0;
               err_q     <= 1'b0;
            end
         endcase
      end
   end

   assign if_ack    = if_ack_q;
   assign d_ack     = d_ack_q;
   assign err       = err_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = req_q.we;
   assign mem_addr  = req_q.addr;
   assign mem_wdata = req_q.wdata;
   assign grant     = grant_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by random traffic
// from both requesters against a transaction-level memory model.
module tb_mem_arbiter;
   import defs_pkg::*;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 4;
   // Expected ack entry: {cycle[15:0], owner[1:0], err, rdata_checked, rdata[15:0]}
   localparam int EW = 36;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic          if_req  = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          d_req   = 1'b0;
   logic          d_we    = 1'b0;
   logic [AW-1:0] d_addr  = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ready = 1'b0;

   logic          if_ack, d_ack, err, mem_req, mem_we;
   logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic [1:0]    grant;
   arb_state_t    state_o;

   mem_arbiter #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT   (TO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_ack   (if_ack),
      .if_rdata (if_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_ack    (d_ack),
      .d_rdata  (d_rdata),
      .err      (err),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .grant    (grant),
      .state_o  (state_o)
   );

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Edge counter and the input values the DUT sees at each rising edge.
   int            cyc = 0;
   logic          s_rst = 1'b1, s_if = 1'b0, s_d = 1'b0, s_d_we = 1'b0;
   logic [AW-1:0] s_if_addr = '0, s_d_addr = '0;
   logic [DW-1:0] s_d_wdata = '0;
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      s_rst     <= reset;
      s_if      <= if_req;
      s_d       <= d_req;
      s_d_we    <= d_we;
      s_if_addr <= if_addr;
      s_d_addr  <= d_addr;
      s_d_wdata <= d_wdata;
   end

   // ---------------- reference model + memory responder ----------------
   logic          busy = 1'b0;
   int            free_edge = 0;
   int            ack_edge = 0;
   int            ready_edge = -1;
   int            w;
   mem_grant_t    last_own = GRANT_IF;
   mem_grant_t    own = GRANT_NONE;
   logic          timed, chk;
   logic [AW-1:0] x_addr;
   logic          x_we;
   logic [DW-1:0] x_wdata, x_rd, rdv;
   logic [DW-1:0] exp_d_rd = '0;
   int            force_w = -1;
   logic          force_rd_en = 1'b0;
   logic [DW-1:0] force_rd = '0;
   logic          spur_ready = 1'b0;

   always @(negedge clk) begin
      if (s_rst) begin
         check("rst_ctrl", {mem_req, mem_we, if_ack, d_ack, err, grant}, 32'd0);
         check("rst_mem_addr", mem_addr, 32'd0);
         check("rst_mem_wdata", mem_wdata, 32'd0);
         check("rst_rdata", {if_rdata, d_rdata}, 32'd0);
         check("rst_state", state_o, ARB_IDLE);
         busy       = 1'b0;
         free_edge  = cyc + 1;
         last_own   = GRANT_IF;
         exp_d_rd   = '0;
         ready_edge = -1;
         exp_q.delete();
      end else begin
         if (!busy && cyc >= free_edge && (s_if || s_d)) begin
            // Tie: serve whichever requester was not served last.
            if (s_if && s_d) own = (last_own == GRANT_IF) ? GRANT_D : GRANT_IF;
            else             own = s_if ? GRANT_IF : GRANT_D;
            busy    = 1'b1;
            x_addr  = (own == GRANT_IF) ? s_if_addr : s_d_addr;
            x_we    = (own == GRANT_D) ? s_d_we : 1'b0;
            x_wdata = s_d_wdata;
            w       = (force_w >= 0) ? force_w : int'($urandom_range(0, 5));
            x_rd    = force_rd_en ? force_rd : DW'($urandom);
            chk     = 1'b1;
            if (w < TO) begin
               timed      = 1'b0;
               ready_edge = cyc + w;
               ack_edge   = cyc + w + 1;
               if (own == GRANT_IF) rdv = x_rd;
               else if (!x_we) begin rdv = x_rd; exp_d_rd = x_rd; end
               else rdv = exp_d_rd;
            end else begin
               timed      = 1'b1;
               ready_edge = -1;
               ack_edge   = cyc + TO;
               rdv        = '0;
               if (own == GRANT_D) begin
                  exp_d_rd = '0;
                  chk      = !x_we;
               end
            end
            exp_q.push_back({16'(ack_edge), own, timed, chk, rdv});
         end

         if (busy) begin
            if (cyc < ack_edge) begin
               check("mem_req_active", mem_req, 32'd1);
               check("grant_active", grant, own);
               check("mem_addr_held", mem_addr, x_addr);
               check("mem_we_held", mem_we, x_we);
               if (own == GRANT_D) check("mem_wdata_held", mem_wdata, x_wdata);
               check("state_mem", state_o, ARB_MEM);
            end else begin
               check("mem_req_dropped", mem_req, 32'd0);
               check("grant_in_ack", grant, own);
               check("state_ack", state_o, ARB_ACK);
               busy      = 1'b0;
               last_own  = own;
               free_edge = ack_edge + 2;
            end
         end else begin
            check("idle_mem_req", mem_req, 32'd0);
            check("idle_grant", grant, 32'd0);
            check("state_idle", state_o, ARB_IDLE);
         end
      end
      mem_ready = (busy && cyc == ready_edge) || spur_ready;
      mem_rdata = (busy && cyc == ready_edge) ? x_rd : DW'($urandom);
   end

   // ---------------- ack monitor / scoreboard ----------------
   logic [EW-1:0] e;
   always @(negedge clk) begin
      if (!s_rst) begin
         if (if_ack || d_ack) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: if_ack=%b d_ack=%b with no access outstanding at cycle %0d",
                        if_ack, d_ack, cyc);
            end else begin
               e = exp_q.pop_front();
               check("ack_cycle", cyc, 32'(e[35:20]));
               check("ack_owner", {d_ack, if_ack}, e[19:18]);
               check("ack_err", err, e[17]);
               if (e[16]) check("ack_rdata", (e[19:18] == 2'd2) ? d_rdata : if_rdata, e[15:0]);
            end
         end else begin
            check("err_outside_ack", err, 32'd0);
            if (exp_q.size() > 0 && int'(exp_q[0][35:20]) < cyc) begin
               e = exp_q.pop_front();
               checks++;
               errors++;
               $display("FAIL missed_ack: no ack, required at cycle %0d (now %0d)", e[35:20], cyc);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic run_fetch(input logic [AW-1:0] a);
      bit seen = 1'b0;
      @(posedge clk); #1;
      if_req  = 1'b1;
      if_addr = a;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(posedge clk); #1;
         if (if_ack) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL fetch_ack_wait: got no if_ack, required within 60 cycles");
      end
      if_req = 1'b0;
   endtask

   task automatic run_data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      bit seen = 1'b0;
      @(posedge clk); #1;
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = a;
      d_wdata = wd;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(posedge clk); #1;
         if (d_ack) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL data_ack_wait: got no d_ack, required within 60 cycles");
      end
      d_req = 1'b0;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   logic [1:0] seq[3];
   int         n;
   bit         seen;

   initial begin
      seq[0] = 2'd0; seq[1] = 2'd0; seq[2] = 2'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Fetch 0x0010, zero-wait memory returning 0xBEEF.
      force_w = 0; force_rd_en = 1'b1; force_rd = 16'hBEEF;
      run_fetch(16'h0010);

      // Store 0x1234 to 0x0040 with 3 wait cycles (ready lands on the expiry cycle).
      force_w = 3; force_rd_en = 1'b0;
      run_data(1'b1, 16'h0040, 16'h1234);

      // Both requesters held across three back-to-back accesses after reset.
      pulse_reset();
      force_w = 0;
      if_req = 1'b1; if_addr = 16'h0100;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200; d_wdata = 16'h5555;
      n = 0;
      for (int i = 0; i < 40 && n < 3; i++) begin
         @(posedge clk); #1;
         if (if_ack || d_ack) begin
            seq[n] = {d_ack, if_ack};
            n++;
         end
      end
      if_req = 1'b0; d_req = 1'b0;
      check("b2b_count", n, 32'd3);
      check("b2b_first", seq[0], 32'd2);
      check("b2b_second", seq[1], 32'd1);
      check("b2b_third", seq[2], 32'd2);

      // Load that never sees mem_ready.
      force_w = 9;
      run_data(1'b0, 16'h0300, 16'h0000);

      // Reset in the middle of a memory access, then a normal fetch.
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 16'h0500;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1; if_req = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      force_w = 1;
      run_fetch(16'h0600);

      // Stray mem_ready while idle, then a load whose address changes mid-access.
      @(posedge clk); #1 spur_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 spur_ready = 1'b0;
      force_w = 3;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0700; d_wdata = 16'h0000;
      repeat (2) @(posedge clk);
      #1 d_addr = 16'h0BAD;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         if (d_ack) seen = 1'b1;
      end
      d_req = 1'b0;
      check("midchange_ack_seen", seen, 32'd1);

      // Random traffic from both requesters.
      force_w = -1;
      fork
         for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_fetch(AW'($urandom));
         end
         for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_data(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
         end
      join

      repeat (10) @(posedge clk);
      #1 check("exp_q_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not reach its summary");
      $fatal(1);
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the CPU's single memory port between the instruction-fetch requester and the load/store data requester driven by the control unit. Requests are granted one at a time, with round-robin priority on ties. Every request ends in exactly one acknowledge pulse. A watchdog terminates any memory access that never receives `mem_ready`. The block sits between the control unit/datapath and the memory interface.

## Interface
- `ADDR_WIDTH`, 16, address width of all ports
- `DATA_WIDTH`, 16, data width of all ports
- `TIMEOUT`, 255, maximum cycles to wait for `mem_ready`; 1..255
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request; held with `if_addr` until `if_ack`
- `if_addr`  in  ADDR_WIDTH  fetch address
- `if_ack`  out  1  one-cycle completion pulse for fetch
- `if_rdata`  out  DATA_WIDTH  fetched word; valid when `if_ack`=1
- `d_req`  in  1  data request; held with `d_we`/`d_addr`/`d_wdata` until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_WIDTH  data address
- `d_wdata`  in  DATA_WIDTH  store data
- `d_ack`  out  1  one-cycle completion pulse for data
- `d_rdata`  out  DATA_WIDTH  load result; valid when `d_ack`=1 and load
- `err`  out  1  qualifies the current `if_ack`/`d_ack`: access timed out
- `mem_req`  out  1  memory access active
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_rdata`  in  DATA_WIDTH  memory read data; valid with `mem_ready`
- `mem_ready`  in  1  memory completes the access this cycle
- `grant`  out  2  current owner: 0 none, 1 fetch, 2 data

## Operation
- All outputs are registered.
- Reset values:
  - `if_ack`, `d_ack`, `err`, `mem_req`, `mem_we` = 0
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0
  - `grant` = 0
  - state = ARB_IDLE
  - `last_grant` = fetch
  - watchdog = 0
- **ARB_IDLE**: samples `if_req`/`d_req`.
  - Only one request high: grant it.
  - Both high: grant the one that is not `last_grant`. After reset, data wins the first tie.
  - On grant:
    - latch the address, `we`, and `wdata` of the winner into the `mem_*` registers;
    - set `mem_req`=1 and `grant`;
    - clear the watchdog;
    - go to ARB_MEM.
  - `mem_we` is forced to 0 for fetch grants.
- **ARB_MEM**: `mem_*` outputs are held constant.
  - `mem_ready`=1: capture `mem_rdata` into `if_rdata` or `d_rdata`. Stores leave `d_rdata` unchanged. Drop `mem_req`, go to ARB_ACK.
  - Otherwise the watchdog increments. When the watchdog reaches `TIMEOUT` without `mem_ready`: drop `mem_req`, set the `err` flag, capture 0 into the owner's rdata, go to ARB_ACK.
- **ARB_ACK**:
  - pulse the owner's ack, plus `err` if it timed out;
  - update `last_grant` to the owner;
  - set `grant`=0;
  - return to ARB_IDLE.
  - Requests are not sampled in this state.
- Request inputs are ignored outside ARB_IDLE. Changing the latched fields mid-access has no effect.
- A request still high in the ARB_IDLE cycle after its ack is treated as a new request.
- `mem_ready` arriving outside ARB_MEM is ignored.
- `mem_ready` arriving in the same cycle the watchdog reaches `TIMEOUT` counts as a normal completion; `err`=0.
- Reset asserted in any state aborts the access: `mem_req` drops on the next edge and no ack is issued.

## Timing
- Latency, request seen at edge N in ARB_IDLE:
  - `mem_req`=1 from cycle N+1;
  - `mem_ready` in cycle M ≥ N+1 gives ack high during cycle M+1;
  - zero-wait memory gives ack 2 cycles after the request.
- Minimum spacing between grants is 3 cycles (IDLE, MEM, ACK).
- Each ack is exactly one cycle. `err` is high only in an ack cycle.
- Timeout: with no `mem_ready`, the ack (with `err`) is high during cycle N+TIMEOUT+1.

## Structure
- Shared in `defs_pkg`:
  - `arb_state_t` {ARB_IDLE, ARB_MEM, ARB_ACK}
  - `mem_grant_t` {GRANT_NONE=0, GRANT_IF=1, GRANT_D=2}
  - `mem_req_t` struct {we, addr, wdata}, used for the latched request
- One sub-module, `arb_watchdog`: 8-bit counter with clear, enable, and an `expired` flag at `TIMEOUT`.

## Test plan
- Fetch 0x0010, memory returns 0xBEEF with zero wait:
  - `mem_req`/`mem_addr`=0x0010 in cycle N+1;
  - `if_ack`=1 and `if_rdata`=0xBEEF in cycle N+2;
  - `err`=0.
- Store 0x1234 to 0x0040, 3 wait cycles:
  - `mem_we`=1 and `mem_wdata`=0x1234 held for 4 cycles;
  - `d_ack` one cycle after `mem_ready`;
  - `d_rdata` unchanged.
- Both requests held continuously, three back-to-back transactions:
  - grants are data, fetch, data;
  - each ack is one cycle;
  - no overlap on `mem_req`.
- `TIMEOUT`=4, `mem_ready` never asserted on a load:
  - `d_ack`=1, `err`=1, `d_rdata`=0 in cycle N+5;
  - state returns to idle.
- Reset pulsed during ARB_MEM:
  - all outputs 0 next cycle, no ack;
  - a subsequent fetch completes normally.
- `mem_ready` asserted while idle and with `d_addr` changed mid-access:
  - no ack from the idle pulse;
  - `mem_addr` keeps the latched value.
